// File: rtl/controller.sv
// Sequencer for a minimal accumulator CPU. Every instruction walks through
// eight states (address, fetch, load, idle, operand address, operand fetch,
// ALU, store). The control strobes are a Moore decode of the current state,
// qualified by the opcode and the accumulator-zero flag. An HLT opcode parks
// the machine in HALTED, which only reset can leave.
module controller #(
    parameter int OPC_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             ld_pc,
    output logic             ld_ac,
    output logic             wr,
    output logic             data_e,
    output logic             halt
);

    localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
    localparam logic [OPC_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
    localparam logic [OPC_W-1:0] OP_AND = 3'd3;
    localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
    localparam logic [OPC_W-1:0] OP_LDA = 3'd5;
    localparam logic [OPC_W-1:0] OP_STO = 3'd6;
    localparam logic [OPC_W-1:0] OP_JMP = 3'd7;

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    state_t state_r;

    logic alu_op_s;
    logic is_hlt_s;
    logic is_skz_s;
    logic is_sto_s;
    logic is_jmp_s;

    // Opcode classification shared by the output decode and the halt branch.
    always_comb begin
        alu_op_s = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
        is_hlt_s = (opcode == OP_HLT);
        is_skz_s = (opcode == OP_SKZ);
        is_sto_s = (opcode == OP_STO);
        is_jmp_s = (opcode == OP_JMP);
    end

    // State sequencer: fixed eight-step cycle, HLT diverts to the absorbing
    // HALTED state, and any corrupted encoding recovers to INST_ADDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= INST_ADDR;
        end else begin
            case (state_r)
                INST_ADDR:  state_r <= INST_FETCH;
                INST_FETCH: state_r <= INST_LOAD;
                INST_LOAD:  state_r <= IDLE;
                IDLE:       state_r <= OP_ADDR;
                OP_ADDR:    state_r <= is_hlt_s ? HALTED : OP_FETCH;
                OP_FETCH:   state_r <= ALU_OP;
                ALU_OP:     state_r <= STORE;
                STORE:      state_r <= INST_ADDR;
                HALTED:     state_r <= HALTED;
                default:    state_r <= INST_ADDR;
            endcase
        end
    end

    // Moore decode of the control strobes. Because reset forces the state
    // register asynchronously, a write or jump in progress is cut off at once.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        case (state_r)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = is_hlt_s;
            end
            OP_FETCH: begin
                rd = alu_op_s;
            end
            ALU_OP: begin
                rd     = alu_op_s;
                inc_pc = is_skz_s && zero;
                ld_pc  = is_jmp_s;
                data_e = is_sto_s;
            end
            STORE: begin
                rd     = alu_op_s;
                ld_ac  = alu_op_s;
                ld_pc  = is_jmp_s;
                wr     = is_sto_s;
                data_e = is_sto_s;
            end
            HALTED: begin
                sel  = 1'b1;
                halt = 1'b1;
            end
            default: begin
                sel = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for the CPU controller. A reference model tracks the
// position inside the eight-cycle instruction and the halted condition, and
// derives the expected strobes from a per-cycle table.
module tb_controller;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

    int tests = 0;
    int fails = 0;

    // model state: position 1..8 inside the instruction, plus halted flag
    int p  = 1;
    bit hf = 1'b0;

    logic [8:0] last_out;

    controller #(.OPC_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
        .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt)
    );

    wire [8:0] dut_out = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bit order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
    function automatic logic [8:0] exp_out(input int pos, input bit h,
                                           input logic [2:0] o, input logic z);
        logic [8:0] v;
        bit alu;
        alu = (o >= 3'd2) && (o <= 3'd5);
        v = 9'b0;
        if (h) begin
            v = 9'b100000001;
        end else begin
            case (pos)
                1: v = 9'b100000000;
                2: v = 9'b110000000;
                3, 4: v = 9'b111000000;
                5: begin v[5] = 1'b1; v[0] = (o == 3'd0); end
                6: v[7] = alu;
                7: begin
                    v[7] = alu; v[5] = (o == 3'd1) && z;
                    v[4] = (o == 3'd7); v[1] = (o == 3'd6);
                end
                8: begin
                    v[7] = alu; v[3] = alu; v[4] = (o == 3'd7);
                    v[2] = (o == 3'd6); v[1] = (o == 3'd6);
                end
                default: v = 9'b0;
            endcase
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] ex);
        tests++;
        assert (obs === ex) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, ex);
        end
    endtask

    // One clock cycle, entered and left just after a rising edge.
    task automatic cyc(input logic [2:0] o, input logic z);
        opcode = o;
        zero   = z;
        @(negedge clk);
        last_out = dut_out;
        chk($sformatf("out op%0d pos%0d h%0d", o, p, hf), dut_out, exp_out(p, hf, o, z));
        chk("wr_implies_data_e", {8'b0, wr & ~data_e}, 9'b0);
        chk("rd_wr_exclusive",   {8'b0, rd & wr},      9'b0);
        @(posedge clk);
        if (!hf) begin
            if (p == 5 && o == 3'd0) hf = 1'b1;
            else p = (p % 8) + 1;
        end
        #1;
    endtask

    // One instruction; zmode 2 randomizes zero every cycle.
    task automatic run_instr(input logic [2:0] o, input int zmode);
        int nsel = 0;
        int nwr  = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(o, (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode));
            nsel += int'(last_out[8]);
            nwr  += int'(last_out[2]);
        end
        chk($sformatf("sel_count op%0d", o), 9'(nsel), 9'd4);
        chk($sformatf("wr_count op%0d", o),  9'(nwr),  (o == 3'd6) ? 9'd1 : 9'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 3'd2;
        zero   = 1'b0;
        #2;
        chk("reset_async", dut_out, 9'b100000000);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_held", dut_out, 9'b100000000);
        rst_n = 1'b1;
        p = 1; hf = 1'b0;

        // directed instruction mix
        run_instr(3'd2, 0);   // ADD
        run_instr(3'd6, 0);   // STO
        run_instr(3'd1, 1);   // SKZ, zero=1
        run_instr(3'd1, 0);   // SKZ, zero=0
        run_instr(3'd7, 0);   // JMP
        run_instr(3'd5, 1);   // LDA
        run_instr(3'd3, 2);   // AND
        run_instr(3'd4, 2);   // XOR

        // random non-halting instructions
        for (int k = 0; k < 30; k++) begin
            run_instr(3'($urandom_range(1, 7)), 2);
        end

        // HLT, then opcodes and zero toggled while halted
        for (int i = 0; i < 5; i++) cyc(3'd0, 1'b0);
        chk("halted_entered", {8'b0, hf}, 9'd1);
        for (int i = 0; i < 20; i++) cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

        // reset from HALTED takes effect without a clock edge
        rst_n = 1'b0;
        #1;
        chk("reset_from_halted", dut_out, 9'b100000000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        p = 1; hf = 1'b0;
        run_instr(3'd2, 0);

        // reset in the middle of STORE of an STO
        for (int i = 0; i < 7; i++) cyc(3'd6, 1'b0);
        #1;
        chk("sto_store_wr", {8'b0, wr}, 9'd1);
        rst_n = 1'b0;
        #1;
        chk("sto_abort_async", dut_out, 9'b100000000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        p = 1; hf = 1'b0;
        run_instr(3'd6, 0);
        run_instr(3'd2, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have parameter OPC_W, default 3, meaning the opcode width; only the value 3 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port opcode, input, OPC_W, the instruction-register opcode field.
REQ-005 The block SHALL have port zero, input, 1, the accumulator-zero flag.
REQ-006 The block SHALL have port sel, output, 1, the address-mux select: 1 = PC (instruction address), 0 = operand address.
REQ-007 The block SHALL have port rd, output, 1, the memory read enable.
REQ-008 The block SHALL have port ld_ir, output, 1, the instruction-register load.
REQ-009 The block SHALL have port inc_pc, output, 1, the PC increment.
REQ-010 The block SHALL have port ld_pc, output, 1, the PC load from the operand address (jump).
REQ-011 The block SHALL have port ld_ac, output, 1, the accumulator load.
REQ-012 The block SHALL have port wr, output, 1, the memory write strobe.
REQ-013 The block SHALL have port data_e, output, 1, the accumulator-to-data-bus drive enable.
REQ-014 The block SHALL have port halt, output, 1, the CPU-halted indication.

Function
REQ-015 Opcodes SHALL be HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7; ALUOP = ADD|AND|XOR|LDA.
REQ-016 The FSM SHALL have nine states: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED.
REQ-017 The FSM SHALL advance one state per clock in the order INST_ADDR->INST_FETCH->INST_LOAD->IDLE->OP_ADDR->OP_FETCH->ALU_OP->STORE->INST_ADDR, so each instruction takes 8 cycles.
REQ-018 In OP_ADDR with opcode==HLT, the next state SHALL be HALTED instead of OP_FETCH.
REQ-019 HALTED SHALL be absorbing and is left only by reset.
REQ-020 All outputs SHALL be Moore outputs: a combinational decode of the registered state plus opcode and zero, with no registered output delay.
REQ-021 INST_ADDR SHALL drive sel=1 and all other outputs 0.
REQ-022 INST_FETCH SHALL drive sel=1 and rd=1.
REQ-023 INST_LOAD and IDLE SHALL each drive sel=1, rd=1 and ld_ir=1.
REQ-024 OP_ADDR SHALL drive inc_pc=1 and halt=(opcode==HLT), with sel=0.
REQ-025 OP_FETCH SHALL drive rd=ALUOP.
REQ-026 ALU_OP SHALL drive rd=ALUOP, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP) and data_e=(opcode==STO).
REQ-027 STORE SHALL drive rd=ALUOP, ld_ac=ALUOP, ld_pc=(opcode==JMP), wr=(opcode==STO) and data_e=(opcode==STO).
REQ-028 HALTED SHALL drive halt=1, sel=1 and all other outputs 0; in particular it SHALL never drive inc_pc, wr or ld_pc.
REQ-029 sel SHALL be 0 in every state from OP_ADDR through STORE.
REQ-030 wr=1 SHALL imply data_e=1 in the same cycle, and data_e SHALL be asserted for the cycle before wr.
REQ-031 rd and wr SHALL never both be 1 in the same cycle.
REQ-032 opcode and zero SHALL be sampled only through the combinational decode; the FSM sequence SHALL NOT depend on them except at REQ-018.
REQ-033 Any state encoding outside the nine legal states SHALL transition to INST_ADDR on the next clock, with all outputs 0 while in it.

Reset
REQ-034 While rst_n=0 the state SHALL be INST_ADDR asynchronously, so outputs are sel=1 and all others 0.
REQ-035 Reset assertion mid-instruction, including from HALTED, SHALL abort immediately with no further wr or ld_pc pulse.
REQ-036 After rst_n deasserts, the first clock edge SHALL move INST_ADDR to INST_FETCH.

Verification
REQ-037 Release reset with opcode=ADD, zero=0 and run 8 clocks -> sel high for exactly 4 cycles, ld_ir high for 2, inc_pc high for 1 (OP_ADDR), rd high in cycles 2-4 and 6-8, ld_ac high in cycle 8, wr never high.
REQ-038 Run opcode=STO -> data_e high in cycles 7-8, wr high only in cycle 8, rd low in cycles 6-8, ld_ac never high.
REQ-039 Run opcode=SKZ with zero=1 -> inc_pc high in cycles 5 and 7; repeat with zero=0 -> inc_pc high only in cycle 5.
REQ-040 Run opcode=JMP -> ld_pc high in cycles 7-8, inc_pc high in cycle 5, wr and ld_ac never high.
REQ-041 Run opcode=HLT -> halt high from cycle 5 onward; hold 20 further clocks with all opcodes toggled -> state stays HALTED; pulse rst_n low -> immediately sel=1, halt=0.
REQ-042 Assert rst_n=0 asynchronously during STORE of an STO instruction -> wr drops within the same cycle without waiting for a clock edge, and the next instruction restarts at INST_ADDR.
